store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side memory sequencer for the kianv pipeline; it is the write counterpart of the load path.
- Accepts one store request per transaction: size from funct3[1:0] (SB/SH/SW), byte address, and rs2 data.
- Produces word-aligned data-memory write beats with byte masks and lane-shifted data, over a valid/ready handshake.
- Stores that cross a word boundary are split into two beats. The unit reports completion or illegal size to the MEM stage.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = flag them as errors without any memory access.
- XLEN, 32, data and address width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_size  in  2  funct3[1:0]: 00 SB, 01 SH, 10 SW, 11 illegal.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  XLEN  word-aligned address, bits [1:0] = 00.
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_wmask  out  4  byte enables; bit i = byte lane i.
- done  out  1  one-cycle pulse: store complete.
- err  out  1  one-cycle pulse: illegal size, or misaligned store with SPLIT_MISALIGNED=0.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous, active-high, and sampled on the rising edge.
- Reset values:
  - state = IDLE.
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0.
  - done = 0, err = 0.
  - req_ready = 1 in the first cycle after reset deasserts.
- req_ready:
  - req_ready = (state == IDLE) && !rst.
  - Accept occurs when req_valid && req_ready at a rising edge.
  - On accept, size, addr and wdata are latched. Inputs are don't-care afterwards.
- Derived quantities (from latched values):
  - off = addr[1:0].
  - smask: SB = 0001, SH = 0011, SW = 1111.
  - wide = {4'b0, smask} << off (8 bits).
  - cross = (wide[7:4] != 0).
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE, on accept:
  - size = 11 -> RESP with err flagged.
  - cross && !SPLIT_MISALIGNED -> RESP with err flagged.
  - Otherwise -> BEAT0.
- BEAT0:
  - mem_valid = 1.
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_wdata = wdata << (8*off).
  - mem_wmask = wide[3:0].
  - On mem_ready: if cross -> BEAT1, else -> RESP.
- BEAT1:
  - mem_valid = 1.
  - mem_addr = {addr[31:2], 2'b00} + 4, modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000).
  - mem_wdata = wdata >> (8*(4-off)).
  - mem_wmask = wide[7:4].
  - On mem_ready -> RESP.
- RESP:
  - Exactly one of done/err is high for exactly one cycle. mem_valid = 0.
  - Next state IDLE.
  - err and done are never high together.
- Handshake rules:
  - While mem_valid && !mem_ready, mem_addr, mem_wdata and mem_wmask are held stable.
  - mem_valid never drops before mem_ready.
  - When mem_valid = 0, mem_wmask = 0. mem_addr and mem_wdata are don't-care.
- Latency:
  - Aligned store, accept at edge E, mem_ready=1 in BEAT0 -> mem handshake at E+1, done high in cycle after E+1, req_ready high after E+2.
  - Split store adds one cycle per extra beat plus any memory wait cycles.
  - Throughput: one request per 3 cycles minimum.
- Boundary conditions:
  - SH with off = 3 and SW with off != 0 cross the word boundary. SB never crosses.
  - mem_ready asserted while mem_valid = 0 is ignored.
  - rst during BEAT0/BEAT1: the beat is abandoned; mem_valid = 0 from the cycle after the reset edge; no done or err.
  - rst in RESP: the pulse is suppressed on the next cycle.
  - req_valid in non-IDLE states is ignored; the request is not queued.

Test Plan:
- SW 0xDEADBEEF @0x100, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, wmask 1111; done pulse 2 cycles after accept; err 0.
- SB 0x000000AB @0x203 -> addr 0x200, wdata 0xAB000000, wmask 1000; done.
- SH 0x1234 @0x107, split -> beat0: addr 0x104, wmask 1000, wdata[31:24] = 0x34. beat1: addr 0x108, wmask 0001, wdata[7:0] = 0x12. Then done.
- SW 0x11223344 @0xFFFFFFFE, mem_ready held low 3 cycles per beat -> beat0: 0xFFFFFFFC, wmask 1100, bytes [31:16] = 0x3344, stable while stalled. beat1: 0x00000000, wmask 0011, bytes [15:0] = 0x1122. Then done.
- req_size = 11, or SW @0x101 with SPLIT_MISALIGNED=0 -> no mem_valid; err pulse one cycle; req_ready returns; done stays 0.
- rst asserted one cycle into a stalled BEAT0 -> mem_valid 0 on the next cycle, no done, req_ready 1 after release; a following SB completes normally.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: store-side sequencer turning one store request into aligned write beats
module store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  output logic            done,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_n;
  logic [1:0] size_q;
  logic [XLEN-1:0] addr_q, wdata_q, base;
  logic err_q, accept, bad_in;
  logic [7:0] wide_in, wide_q;
  function automatic logic [7:0] wide_of(input logic [1:0] sz, input logic [1:0] off);
    return {4'b0000, sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111} << off;
  endfunction
  assign wide_in = wide_of(req_size, req_addr[1:0]);
  assign wide_q  = wide_of(size_q, addr_q[1:0]);
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign bad_in = req_size == 2'b11 || (wide_in[7:4] != 4'b0000 && !SPLIT_MISALIGNED);
  assign base = {addr_q[XLEN-1:2], 2'b00};
  // state register and request capture; the error verdict is decided at accept time
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad_in;
      end
    end
  end
  // next state: a second beat is only needed when the shifted mask spills past lane 3
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = bad_in ? RESP : BEAT0;
      BEAT0:   if (mem_ready) state_n = wide_q[7:4] != 4'b0000 ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // beat outputs derive only from state and captured request, so they hold during stalls
  always_comb begin
    mem_valid = state == BEAT0 || state == BEAT1;
    mem_addr  = state == BEAT1 ? base + XLEN'(4) : base;
    mem_wdata = state == BEAT1 ? wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000})
                               : wdata_q << {addr_q[1:0], 3'b000};
    mem_wmask = state == BEAT0 ? wide_q[3:0] : state == BEAT1 ? wide_q[7:4] : 4'b0000;
    done      = state == RESP && !err_q;
    err       = state == RESP && err_q;
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard bench for store_unit beats, responses and reset behaviour
module tb_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_valid_ns = 1'b0, mem_ready = 1'b1;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic req_ready_ns, mem_valid_ns, done_ns, err_ns;
  logic [31:0] mem_addr_ns, mem_wdata_ns;
  logic [3:0] mem_wmask_ns;
  int vec = 0, fails = 0;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] m;} beat_t;
  beat_t q[$];

  store_unit #(.SPLIT_MISALIGNED(1'b1), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .done(done), .err(err));

  store_unit #(.SPLIT_MISALIGNED(1'b0), .XLEN(32)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid_ns), .mem_ready(mem_ready), .mem_addr(mem_addr_ns),
    .mem_wdata(mem_wdata_ns), .mem_wmask(mem_wmask_ns), .done(done_ns), .err(err_ns));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      vec++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: addr=%h wdata=%h wmask=%b, no beat was expected", mem_addr, mem_wdata, mem_wmask);
      end else begin
        beat_t b;
        b = q.pop_front();
        if ({mem_addr, mem_wdata, mem_wmask} !== b) begin
          fails++;
          $display("FAIL beat: got addr=%h wdata=%h wmask=%b, want addr=%h wdata=%h wmask=%b",
                   mem_addr, mem_wdata, mem_wmask, b.a, b.d, b.m);
        end
      end
    end
    if (!mem_valid) begin
      vec++;
      if (mem_wmask !== 4'b0000) begin
        fails++;
        $display("FAIL idle_wmask: got %b want 0000", mem_wmask);
      end
    end
  end

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_size = sz; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hXXXX_XXXX; req_wdata = 32'hXXXX_XXXX;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < 20);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({req_ready, mem_valid, mem_wmask, mem_addr, mem_wdata, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_state: ready=%b valid=%b wmask=%b addr=%h wdata=%h done=%b err=%b, want all 0",
               req_ready, mem_valid, mem_wmask, mem_addr, mem_wdata, done, err);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_single(input string nm, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] ea, input logic [31:0] ed,
                             input logic [3:0] em);
    int n;
    mem_ready = 1'b1;
    q.push_back('{ea, ed, em});
    issue(sz, a, d);
    wait_resp(n);
    vec++;
    if (n !== 2 || done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s_resp: latency=%0d done=%b err=%b, want latency=2 done=1 err=0", nm, n, done, err);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_after: done=%b ready=%b, want done=0 ready=1", nm, done, req_ready);
    end
  endtask

  task automatic test_sh_split;
    int n;
    mem_ready = 1'b1;
    q.push_back('{32'h0000_0104, 32'h3400_0000, 4'b1000});
    q.push_back('{32'h0000_0108, 32'h0000_0012, 4'b0001});
    issue(2'b01, 32'h0000_0107, 32'h0000_1234);
    wait_resp(n);
    vec++;
    if (n !== 3 || done !== 1'b1 || err !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL sh_split: latency=%0d done=%b err=%b pending=%0d, want 3 1 0 0", n, done, err, q.size());
    end
  endtask

  task automatic test_sw_wrap_stall;
    int n;
    beat_t b0, b1;
    b0 = '{32'hFFFF_FFFC, 32'h3344_0000, 4'b1100};
    b1 = '{32'h0000_0000, 32'h0000_1122, 4'b0011};
    q.push_back(b0);
    q.push_back(b1);
    mem_ready = 1'b0;
    issue(2'b10, 32'hFFFF_FFFE, 32'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (mem_valid !== 1'b1 || {mem_addr, mem_wdata, mem_wmask} !== b0) begin
        fails++;
        $display("FAIL wrap_stall0: valid=%b addr=%h wdata=%h wmask=%b, want 1 %h %h %b",
                 mem_valid, mem_addr, mem_wdata, mem_wmask, b0.a, b0.d, b0.m);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (mem_valid !== 1'b1 || {mem_addr, mem_wdata, mem_wmask} !== b1) begin
        fails++;
        $display("FAIL wrap_stall1: valid=%b addr=%h wdata=%h wmask=%b, want 1 %h %h %b",
                 mem_valid, mem_addr, mem_wdata, mem_wmask, b1.a, b1.d, b1.m);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    wait_resp(n);
    vec++;
    if (done !== 1'b1 || err !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL wrap_done: done=%b err=%b pending=%0d, want 1 0 0", done, err, q.size());
    end
  endtask

  task automatic test_illegal;
    int n;
    mem_ready = 1'b1;
    issue(2'b11, 32'h0000_0100, 32'hCAFE_F00D);
    wait_resp(n);
    vec++;
    if (n !== 1 || err !== 1'b1 || done !== 1'b0 || mem_valid !== 1'b0) begin
      fails++;
      $display("FAIL illegal_resp: latency=%0d err=%b done=%b valid=%b, want 1 1 0 0", n, err, done, mem_valid);
    end
    @(negedge clk);
    vec++;
    if (err !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_after: err=%b ready=%b, want 0 1", err, req_ready);
    end
  endtask

  task automatic test_nosplit;
    int errs = 0;
    logic saw_v = 1'b0, saw_d = 1'b0;
    @(posedge clk); #1;
    req_size = 2'b10; req_addr = 32'h0000_0101; req_wdata = 32'h5555_AAAA; req_valid_ns = 1'b1;
    @(posedge clk); #1 req_valid_ns = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_v |= mem_valid_ns;
      saw_d |= done_ns;
      if (err_ns) errs++;
    end
    vec++;
    if (errs != 1 || saw_v !== 1'b0 || saw_d !== 1'b0 || req_ready_ns !== 1'b1) begin
      fails++;
      $display("FAIL nosplit: err_cycles=%0d saw_valid=%b saw_done=%b ready=%b, want 1 0 0 1",
               errs, saw_v, saw_d, req_ready_ns);
    end
  endtask

  task automatic test_reset_midbeat;
    int n;
    logic bad = 1'b0;
    mem_ready = 1'b0;
    issue(2'b10, 32'h0000_0300, 32'h0BAD_0BAD);
    @(negedge clk);
    vec++;
    if (mem_valid !== 1'b1) begin
      fails++;
      $display("FAIL midbeat_stall: valid=%b want 1", mem_valid);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if (mem_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL midbeat_reset: valid=%b done=%b err=%b ready=%b, want 0 0 0 1", mem_valid, done, err, req_ready);
    end
    repeat (3) begin
      @(negedge clk);
      bad |= done | err | mem_valid;
    end
    vec++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL midbeat_quiet: activity=%b want 0", bad);
    end
    test_single("after_rst_sb", 2'b00, 32'h0000_0001, 32'h0000_005A, 32'h0000_0000, 32'h0000_5A00, 4'b0010);
  endtask

  task automatic test_back_to_back;
    int dn = 0;
    mem_ready = 1'b1;
    q.push_back('{32'h0000_0040, 32'h0000_0055, 4'b1111});
    q.push_back('{32'h0000_0040, 32'h0000_0055, 4'b1111});
    @(posedge clk); #1;
    req_size = 2'b10; req_addr = 32'h0000_0040; req_wdata = 32'h0000_0055; req_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    vec++;
    if (dn != 2 || q.size() != 0) begin
      fails++;
      $display("FAIL back_to_back: done_pulses=%0d pending=%0d, want 2 0", dn, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("sw_aligned", 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    test_single("sb_lane3", 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'h0000_0200, 32'hAB00_0000, 4'b1000);
    test_single("sh_lane2", 2'b01, 32'h0000_0012, 32'hFFFF_BEEF, 32'h0000_0010, 32'hBEEF_0000, 4'b1100);
    test_sh_split();
    test_sw_wrap_stall();
    test_illegal();
    test_nosplit();
    test_reset_midbeat();
    test_back_to_back();
    vec++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d beats never seen, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
